prime_sieve_ctrl: RTL and testbench
===================================

PRIME_SIEVE_CTRL -- requirements
Module: prime_sieve_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIVISOR, default 255, highest trial divisor issued (legal 2..255).
REQ-002 SHALL have port aclk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_axis_cand_tvalid  in  1  candidate valid.
REQ-005 SHALL have port s_axis_cand_tdata  in  16  candidate value.
REQ-006 SHALL have port s_axis_cand_tready  out  1  candidate accepted on tvalid&tready.
REQ-007 SHALL have port m_axis_dividend_tvalid  out  1  dividend valid to divider.
REQ-008 SHALL have port m_axis_dividend_tdata  out  16  dividend (latched candidate).
REQ-009 SHALL have port m_axis_divisor_tvalid  out  1  divisor valid to divider.
REQ-010 SHALL have port m_axis_divisor_tdata  out  8  trial divisor.
REQ-011 SHALL have port s_axis_dout_tvalid  in  1  divider result valid (non-blocking divider, no tready).
REQ-012 SHALL have port s_axis_dout_tdata  in  24  [23:8] quotient, [7:0] remainder.
REQ-013 SHALL have port res_valid  out  1  verdict valid.
REQ-014 SHALL have port res_ready  in  1  verdict consumed on res_valid&res_ready.
REQ-015 SHALL have port res_prime  out  1  1 = candidate prime.
REQ-016 SHALL have port res_candidate  out  16  candidate the verdict refers to.
REQ-017 SHALL have port res_factor  out  8  smallest factor found; 0 when prime or candidate<2.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, REPORT; s_axis_cand_tready=1 only in IDLE.
REQ-019 IDLE: on candidate handshake with value >=2 SHALL latch it, set trial divisor to 2, go ISSUE; with value 0 or 1 SHALL go REPORT with res_prime=0, res_factor=0, no divider traffic.
REQ-020 ISSUE: SHALL hold m_axis_dividend_tvalid=1 with latched candidate and present one divisor per cycle with m_axis_divisor_tvalid=1, incrementing 2,3,...,MAX_DIVISOR, counting issued divisors.
REQ-021 After issuing MAX_DIVISOR SHALL drop both m_axis tvalids next cycle and go DRAIN.
REQ-022 Results SHALL be attributed in order: k-th received result (k from 0) belongs to divisor 2+k; results accepted in both ISSUE and DRAIN.
REQ-023 A result SHALL mark composite iff remainder==0 and quotient!=1 (divisor equal to candidate is not a factor); first such result sets res_factor, later ones do not change it.
REQ-024 DRAIN: SHALL go REPORT the cycle after received count equals issued count; res_valid asserts that cycle.
REQ-025 s_axis_dout_tvalid in IDLE or REPORT SHALL be ignored.
REQ-026 REPORT: res_valid, res_prime, res_candidate, res_factor SHALL hold stable until res_ready=1, then go IDLE next cycle.
REQ-027 res_prime SHALL equal 1 iff candidate>=2 and no composite mark recorded.
REQ-028 Issued/received counters SHALL be 9 bits wide so 254 outstanding results never wrap.

Reset
REQ-029 aresetn=0 SHALL asynchronously force IDLE, s_axis_cand_tready=1 after release, all m_axis tvalids=0, res_valid=0, res_prime=0, res_candidate=0, res_factor=0, counters=0.
REQ-030 Reset mid-ISSUE/DRAIN SHALL abandon the candidate; results arriving after reset release SHALL be ignored (IDLE).

Configuration
REQ-031 Macro SIEVE_EARLY_ABORT_EN defined: on first composite mark during ISSUE, SHALL stop issuing next cycle and go DRAIN, draining only divisors already issued.
REQ-032 SIEVE_EARLY_ABORT_EN undefined: SHALL always issue the full 2..MAX_DIVISOR sweep; verdicts identical either way.

Verification
REQ-033 Candidate 59477 -> res_prime=0, res_factor=11, res_candidate=59477.
REQ-034 Candidate 65521 -> res_prime=1, res_factor=0; exactly 254 divisor beats issued.
REQ-035 Candidate 251 -> res_prime=1 (divisor 251 gives quotient 1, not counted); candidate 4 -> res_prime=0, res_factor=2.
REQ-036 Candidates 0 and 1 -> res_prime=0, res_factor=0 with no divider tvalid ever asserted.
REQ-037 Candidate 65535 with SIEVE_EARLY_ABORT_EN -> res_factor=3, fewer than 254 divisors issued; res_ready held low 10 cycles -> outputs stable, tready=0.
REQ-038 aresetn pulsed low mid-ISSUE on 65521 -> outputs at reset values immediately; next candidate 59477 reports factor 11 correctly.

Source files
------------

// File: rtl/prime_sieve_ctrl_if.sv
// Bundled candidate, divider and verdict streams of prime_sieve_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface prime_sieve_ctrl_if;
    logic        s_axis_cand_tvalid;
    logic [15:0] s_axis_cand_tdata;
    logic        s_axis_cand_tready;

    logic        m_axis_dividend_tvalid;
    logic [15:0] m_axis_dividend_tdata;
    logic        m_axis_divisor_tvalid;
    logic [7:0]  m_axis_divisor_tdata;

    logic        s_axis_dout_tvalid;
    logic [23:0] s_axis_dout_tdata;

    logic        res_valid;
    logic        res_ready;
    logic        res_prime;
    logic [15:0] res_candidate;
    logic [7:0]  res_factor;

    modport slave (
        input  s_axis_cand_tvalid, s_axis_cand_tdata,
        output s_axis_cand_tready,
        output m_axis_dividend_tvalid, m_axis_dividend_tdata,
        output m_axis_divisor_tvalid, m_axis_divisor_tdata,
        input  s_axis_dout_tvalid, s_axis_dout_tdata,
        output res_valid, res_prime, res_candidate, res_factor,
        input  res_ready
    );

    modport master (
        output s_axis_cand_tvalid, s_axis_cand_tdata,
        input  s_axis_cand_tready,
        input  m_axis_dividend_tvalid, m_axis_dividend_tdata,
        input  m_axis_divisor_tvalid, m_axis_divisor_tdata,
        output s_axis_dout_tvalid, s_axis_dout_tdata,
        input  res_valid, res_prime, res_candidate, res_factor,
        output res_ready
    );
endinterface

// File: rtl/prime_sieve_ctrl.sv
// Trial-division primality controller driving an external pipelined divider.
// Optional macro SIEVE_EARLY_ABORT_EN stops issuing divisors on the first factor found.
module prime_sieve_ctrl #(
    parameter int MAX_DIVISOR = 255
) (
    input  logic               aclk,
    input  logic               aresetn,
    prime_sieve_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

    localparam logic [7:0] LAST_DIV = 8'(MAX_DIVISOR);

    state_t      state, state_nxt;
    logic [15:0] cand;
    logic [7:0]  divisor;
    logic [7:0]  factor;
    logic [8:0]  issued;
    logic [8:0]  received;
    logic        composite;

    logic        cand_fire;
    logic        dout_take;
    logic        hit;
    logic        last_issue;
    logic [15:0] quot;
    logic [7:0]  rem;

    assign cand_fire  = bus.s_axis_cand_tvalid && (state == IDLE);
    assign dout_take  = bus.s_axis_dout_tvalid && ((state == ISSUE) || (state == DRAIN));
    assign quot       = bus.s_axis_dout_tdata[23:8];
    assign rem        = bus.s_axis_dout_tdata[7:0];
    // A quotient of 1 means the divisor is the candidate itself, not a proper factor.
    assign hit        = dout_take && (rem == 8'd0) && (quot != 16'd1);
    assign last_issue = (divisor == LAST_DIV);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cand_fire)
                    state_nxt = (bus.s_axis_cand_tdata >= 16'd2) ? ISSUE : REPORT;
            end
            ISSUE: begin
                if (last_issue) state_nxt = DRAIN;
`ifdef SIEVE_EARLY_ABORT_EN
                if (hit) state_nxt = DRAIN;
`endif
            end
            DRAIN: begin
                if (received == issued) state_nxt = REPORT;
            end
            REPORT: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cand      <= '0;
            divisor   <= '0;
            factor    <= '0;
            issued    <= '0;
            received  <= '0;
            composite <= 1'b0;
        end else begin
            if (cand_fire) begin
                cand      <= bus.s_axis_cand_tdata;
                divisor   <= 8'd2;
                factor    <= '0;
                issued    <= '0;
                received  <= '0;
                composite <= 1'b0;
            end
            if (state == ISSUE) begin
                issued <= issued + 9'd1;
                if (!last_issue) divisor <= divisor + 8'd1;
            end
            // Divider returns results in issue order, so the k-th result is divisor 2+k.
            if (dout_take) begin
                received <= received + 9'd1;
                if (hit && !composite) begin
                    composite <= 1'b1;
                    factor    <= received[7:0] + 8'd2;
                end
            end
        end
    end

    assign bus.s_axis_cand_tready     = (state == IDLE);
    assign bus.m_axis_dividend_tvalid = (state == ISSUE);
    assign bus.m_axis_dividend_tdata  = cand;
    assign bus.m_axis_divisor_tvalid  = (state == ISSUE);
    assign bus.m_axis_divisor_tdata   = divisor;
    assign bus.res_valid              = (state == REPORT);
    assign bus.res_prime              = (state == REPORT) && (cand >= 16'd2) && !composite;
    assign bus.res_candidate          = cand;
    assign bus.res_factor             = factor;

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// Randomized and directed bench for prime_sieve_ctrl with an in-order divider model.
module tb_prime_sieve_ctrl;

    localparam int MAX_DIV = 255;
    localparam int LAT     = 4;

    logic aclk;
    logic aresetn;
    prime_sieve_ctrl_if bus();

    prime_sieve_ctrl #(.MAX_DIVISOR(MAX_DIV)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic [23:0] data;
    } pend_t;

    pend_t       pend[$];
    int          cyc       = 0;
    int          any_beats = 0;
    int          seq_err   = 0;
    int          exp_div   = 2;
    logic        prev_vld  = 1'b0;
    logic [15:0] cur_cand  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Fixed-latency divider: each issued beat comes back LAT cycles later, in order.
    initial begin
        int q;
        int r;
        bus.s_axis_dout_tvalid = 1'b0;
        bus.s_axis_dout_tdata  = '0;
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            if (bus.m_axis_dividend_tvalid || bus.m_axis_divisor_tvalid) any_beats++;
            if (bus.m_axis_divisor_tvalid) begin
                if (!prev_vld) exp_div = 2;
                if (int'(bus.m_axis_divisor_tdata) != exp_div || bus.m_axis_dividend_tvalid !== 1'b1
                    || bus.m_axis_dividend_tdata !== cur_cand)
                    seq_err++;
                exp_div++;
                if (bus.m_axis_divisor_tdata == 8'd0) begin
                    q = 0;
                    r = 0;
                end else begin
                    q = int'(bus.m_axis_dividend_tdata) / int'(bus.m_axis_divisor_tdata);
                    r = int'(bus.m_axis_dividend_tdata) % int'(bus.m_axis_divisor_tdata);
                end
                pend.push_back('{due: cyc + LAT, data: {q[15:0], r[7:0]}});
            end
            prev_vld = bus.m_axis_divisor_tvalid;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                bus.s_axis_dout_tvalid = 1'b1;
                bus.s_axis_dout_tdata  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                bus.s_axis_dout_tvalid = 1'b0;
                bus.s_axis_dout_tdata  = 24'($urandom);
            end
        end
    end

    function automatic void ref_model(input int n, output logic prime, output logic [7:0] fac);
        prime = 1'b0;
        fac   = '0;
        if (n < 2) return;
        for (int d = 2; d <= MAX_DIV; d++) begin
            if (n % d == 0 && n / d != 1) begin
                fac = 8'(d);
                return;
            end
        end
        prime = 1'b1;
    endfunction

    task automatic run_cand(input logic [15:0] n, input int hold);
        int         a0, s0, beats;
        logic       got;
        logic       e_prime;
        logic [7:0] e_fac;
        ref_model(int'(n), e_prime, e_fac);
        a0 = any_beats;
        s0 = seq_err;
        cur_cand = n;
        check("idle_tready", bus.s_axis_cand_tready, 1);
        bus.s_axis_cand_tvalid = 1'b1;
        bus.s_axis_cand_tdata  = n;
        @(posedge aclk);
        #1;
        bus.s_axis_cand_tvalid = 1'b0;
        bus.s_axis_cand_tdata  = 16'($urandom);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        check("res_valid_timeout", got, 1);
        repeat (hold) begin
            @(posedge aclk);
            #1;
        end
        beats = any_beats - a0;
        check("hold_valid", bus.res_valid, 1);
        check("hold_tready", bus.s_axis_cand_tready, 0);
        check("res_prime", bus.res_prime, e_prime);
        check("res_factor", bus.res_factor, e_fac);
        check("res_candidate", bus.res_candidate, n);
        check("divisor_seq", seq_err - s0, 0);
        if (n < 2) check("beats_small", beats, 0);
`ifdef SIEVE_EARLY_ABORT_EN
        else if (e_prime) check("beats_prime", beats, MAX_DIV - 1);
        else check("beats_le_full", (beats <= MAX_DIV - 1), 1);
`else
        else check("beats_full", beats, MAX_DIV - 1);
`endif
        bus.res_ready = 1'b1;
        @(posedge aclk);
        #1;
        bus.res_ready = 1'b0;
        check("release_valid", bus.res_valid, 0);
        check("release_tready", bus.s_axis_cand_tready, 1);
    endtask

    initial begin
        int a0;
        logic [15:0] n;
        aresetn                = 1'b0;
        bus.s_axis_cand_tvalid = 1'b0;
        bus.s_axis_cand_tdata  = '0;
        bus.res_ready          = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_tready", bus.s_axis_cand_tready, 1);
        check("rst_dividend_vld", bus.m_axis_dividend_tvalid, 0);
        check("rst_divisor_vld", bus.m_axis_divisor_tvalid, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_prime", bus.res_prime, 0);
        check("rst_res_candidate", bus.res_candidate, 0);
        check("rst_res_factor", bus.res_factor, 0);

        run_cand(16'd59477, 2);
        run_cand(16'd65521, 0);
        run_cand(16'd251, 1);
        run_cand(16'd4, 0);
        run_cand(16'd0, 3);
        run_cand(16'd1, 0);
        run_cand(16'd2, 0);
        run_cand(16'd63001, 0);

        a0 = any_beats;
        run_cand(16'd65535, 10);
`ifdef SIEVE_EARLY_ABORT_EN
        check("abort_fewer_beats", ((any_beats - a0) < MAX_DIV - 1), 1);
`endif

        for (int i = 0; i < 12; i++) begin
            n = (i % 2 == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom_range(0, 65535));
            run_cand(n, int'($urandom_range(0, 3)));
        end

        // Abandon a candidate mid-sweep; its late results land in IDLE.
        cur_cand = 16'd65521;
        bus.s_axis_cand_tvalid = 1'b1;
        bus.s_axis_cand_tdata  = 16'd65521;
        @(posedge aclk);
        #1;
        bus.s_axis_cand_tvalid = 1'b0;
        repeat (20) @(posedge aclk);
        #1;
        check("mid_issue_active", bus.m_axis_divisor_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("async_dividend_vld", bus.m_axis_dividend_tvalid, 0);
        check("async_divisor_vld", bus.m_axis_divisor_tvalid, 0);
        check("async_res_valid", bus.res_valid, 0);
        check("async_res_prime", bus.res_prime, 0);
        check("async_res_candidate", bus.res_candidate, 0);
        check("async_res_factor", bus.res_factor, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (LAT + 6) @(posedge aclk);
        #1;
        check("post_rst_tready", bus.s_axis_cand_tready, 1);
        check("post_rst_res_valid", bus.res_valid, 0);
        run_cand(16'd59477, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
